// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin two-master arbiter for a 1-cycle-latency synchronous RAM port
module ram_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RAM_BYTES = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RWAIT, RESP} state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   id_q, id_d;
    logic   we_q, we_d;
    logic   ok_q, ok_d;

    logic              m0_gnt_d, m1_gnt_d, m0_rvalid_d, m1_rvalid_d;
    logic [DATA_W-1:0] m0_rdata_d, m1_rdata_d;
    logic              ram_en_d, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_d;

    // Winner selection: a lone requester wins; on a tie the master not served last wins.
    logic              sel_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_ok;
    logic [DATA_W-1:0] rd_value;

    assign sel_id    = (m0_req && m1_req) ? ~last_q : m1_req;
    assign sel_we    = sel_id ? m1_we    : m0_we;
    assign sel_addr  = sel_id ? m1_addr  : m0_addr;
    assign sel_wdata = sel_id ? m1_wdata : m0_wdata;
    assign sel_ok    = sel_addr < ADDR_W'(RAM_BYTES);
    assign rd_value  = ok_q ? ram_rdata : '0;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        we_d        = we_q;
        ok_d        = ok_q;
        m0_gnt_d    = 1'b0;
        m1_gnt_d    = 1'b0;
        m0_rvalid_d = 1'b0;
        m1_rvalid_d = 1'b0;
        m0_rdata_d  = m0_rdata;
        m1_rdata_d  = m1_rdata;
        ram_en_d    = 1'b0;
        ram_we_d    = ram_we;
        ram_addr_d  = ram_addr;
        ram_wdata_d = ram_wdata;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    id_d     = sel_id;
                    last_d   = sel_id;
                    we_d     = sel_we;
                    ok_d     = sel_ok;
                    m0_gnt_d = ~sel_id;
                    m1_gnt_d = sel_id;
                    // Out-of-range accesses are granted but never reach the RAM.
                    if (sel_ok) begin
                        ram_en_d    = 1'b1;
                        ram_we_d    = sel_we;
                        ram_addr_d  = sel_addr;
                        ram_wdata_d = sel_wdata;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: state_d = we_q ? IDLE : RWAIT;
            RWAIT: begin
                if (id_q) begin
                    m1_rdata_d  = rd_value;
                    m1_rvalid_d = 1'b1;
                end else begin
                    m0_rdata_d  = rd_value;
                    m0_rvalid_d = 1'b1;
                end
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            id_q      <= 1'b0;
            we_q      <= 1'b0;
            ok_q      <= 1'b0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            id_q      <= id_d;
            we_q      <= we_d;
            ok_q      <= ok_d;
            m0_gnt    <= m0_gnt_d;
            m1_gnt    <= m1_gnt_d;
            m0_rvalid <= m0_rvalid_d;
            m1_rvalid <= m1_rvalid_d;
            m0_rdata  <= m0_rdata_d;
            m1_rdata  <= m1_rdata_d;
            ram_en    <= ram_en_d;
            ram_we    <= ram_we_d;
            ram_addr  <= ram_addr_d;
            ram_wdata <= ram_wdata_d;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed and randomized checks of ram_port_arbiter against a transaction-timing model
module tb_ram_port_arbiter;

    localparam int MAXC = 2048;

    logic        clk, reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_en, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    ram_port_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with one cycle of read latency.
    bit [31:0] ram_mem [1024];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr[11:2]] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr[11:2]];
        end
    end

    // Reference model: expected outputs per cycle, derived from arbitration instants.
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          free_at = 0;
    bit          last_m = 1'b1;
    bit [31:0]   ref_mem [1024];
    bit          exp_gnt [2][MAXC];
    bit          exp_rv  [2][MAXC];
    logic [31:0] exp_rd  [2][MAXC];
    bit          exp_en  [MAXC];
    bit          exp_we  [MAXC];
    logic [31:0] exp_addr  [MAXC];
    logic [31:0] exp_wdata [MAXC];
    logic [31:0] hold [2];
    int          gq [$];
    bit          pend [2];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < MAXC; i++) begin
            for (int m = 0; m < 2; m++) begin
                exp_gnt[m][i] = 1'b0; exp_rv[m][i] = 1'b0; exp_rd[m][i] = '0;
            end
            exp_en[i] = 1'b0; exp_we[i] = 1'b0; exp_addr[i] = '0; exp_wdata[i] = '0;
        end
        cyc = 0; free_at = 0; last_m = 1'b1; hold[0] = '0; hold[1] = '0;
    endtask

    task automatic drive(int m, bit r, bit w, logic [31:0] a, logic [31:0] d);
        if (m == 0) begin m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d; end
        else        begin m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d; end
    endtask

    task automatic model_arb();
        int w; bit we; logic [31:0] a, d; bit inr;
        if (cyc >= free_at && (m0_req || m1_req)) begin
            if (m0_req && m1_req) w = last_m ? 0 : 1;
            else                  w = m1_req ? 1 : 0;
            last_m = w[0];
            we = w ? m1_we : m0_we;
            a  = w ? m1_addr : m0_addr;
            d  = w ? m1_wdata : m0_wdata;
            inr = a < 32'd4096;
            exp_gnt[w][cyc+1] = 1'b1;
            if (inr) begin
                exp_en[cyc+1] = 1'b1; exp_we[cyc+1] = we;
                exp_addr[cyc+1] = a; exp_wdata[cyc+1] = d;
                if (we) ref_mem[a[11:2]] = d;
            end
            if (we) free_at = cyc + 2;
            else begin
                exp_rv[w][cyc+3] = 1'b1;
                exp_rd[w][cyc+3] = inr ? ref_mem[a[11:2]] : 32'h0;
                free_at = cyc + 4;
            end
        end
    endtask

    task automatic check_outputs();
        logic g [2]; logic rv [2]; logic [31:0] rd [2];
        g[0] = m0_gnt; g[1] = m1_gnt; rv[0] = m0_rvalid; rv[1] = m1_rvalid;
        rd[0] = m0_rdata; rd[1] = m1_rdata;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("m%0d_gnt@%0d", m, cyc), 32'(g[m]), 32'(exp_gnt[m][cyc]));
            if (g[m] === 1'b1) gq.push_back(m);
            if (exp_rv[m][cyc]) hold[m] = exp_rd[m][cyc];
            chk($sformatf("m%0d_rvalid@%0d", m, cyc), 32'(rv[m]), 32'(exp_rv[m][cyc]));
            chk($sformatf("m%0d_rdata@%0d", m, cyc), rd[m], hold[m]);
        end
        chk($sformatf("ram_en@%0d", cyc), 32'(ram_en), 32'(exp_en[cyc]));
        if (exp_en[cyc]) begin
            chk($sformatf("ram_we@%0d", cyc), 32'(ram_we), 32'(exp_we[cyc]));
            chk($sformatf("ram_addr@%0d", cyc), ram_addr, exp_addr[cyc]);
            chk($sformatf("ram_wdata@%0d", cyc), ram_wdata, exp_wdata[cyc]);
        end
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_gnt"}, 32'({m0_gnt, m1_gnt}), 32'h0);
        chk({tag, "_rvalid"}, 32'({m0_rvalid, m1_rvalid}), 32'h0);
        chk({tag, "_m0_rdata"}, m0_rdata, 32'h0);
        chk({tag, "_m1_rdata"}, m1_rdata, 32'h0);
        chk({tag, "_ram_en_we"}, 32'({ram_en, ram_we}), 32'h0);
        chk({tag, "_ram_addr"}, ram_addr, 32'h0);
        chk({tag, "_ram_wdata"}, ram_wdata, 32'h0);
    endtask

    task automatic tick();
        model_arb();
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && cyc < free_at; k++) tick();
        tick();
    endtask

    task automatic single(int m, bit w, logic [31:0] a, logic [31:0] d);
        bit got = 1'b0;
        drive(m, 1'b1, w, a, d);
        for (int k = 0; k < 16 && !got; k++) begin
            tick();
            got = exp_gnt[m][cyc];
        end
        chk($sformatf("single_m%0d_granted", m), 32'(got), 32'h1);
        drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
        drain();
    endtask

    task automatic new_random(int m);
        logic [31:0] a;
        if ($urandom_range(0, 7) == 0) a = 32'h1000 + ($urandom & 32'h7fff_fffc);
        else                           a = 32'($urandom_range(0, 63)) << 2;
        drive(m, 1'b1, 1'($urandom_range(0, 1)), a, $urandom);
        pend[m] = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b1;
        reset_model();

        single(0, 1'b1, 32'h10, 32'hDEADBEEF);
        single(1, 1'b0, 32'h10, 32'h0);

        // Continuous contention: each master re-requests a fresh write right after its grant.
        gq.delete();
        drive(0, 1'b1, 1'b1, 32'h100, 32'hA0A0_0000);
        drive(1, 1'b1, 1'b1, 32'h104, 32'hB1B1_0000);
        for (int k = 0; k < 40 && gq.size() < 6; k++) begin
            tick();
            for (int m = 0; m < 2; m++)
                if (exp_gnt[m][cyc]) drive(m, 1'b1, 1'b1, 32'h100 + 32'(8 * k + 4 * m), 32'(k));
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        drain();
        chk("rr_grant_count", 32'(gq.size()), 32'd6);
        for (int i = 0; i < gq.size() && i < 6; i++)
            chk($sformatf("rr_order_%0d", i), 32'(gq[i]), 32'(i % 2));

        single(0, 1'b0, 32'h1000, 32'h0);
        single(0, 1'b1, 32'h8000_0000, 32'h5555_AAAA);

        // m0 pulses req for one cycle while m1 occupies ACCESS.
        drive(1, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
        tick();
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(0, 1'b1, 1'b1, 32'h24, 32'hCAFE_F00D);
        tick();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drain();
        repeat (3) tick();

        // Reset during RWAIT of an m1 read.
        drive(1, 1'b1, 1'b0, 32'h10, 32'h0);
        tick();
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        reset = 1'b0;
        #1 check_zero("rwait_reset");
        @(negedge clk);
        check_zero("reset_held");
        reset = 1'b1;
        reset_model();
        repeat (6) tick();

        gq.delete();
        drive(0, 1'b1, 1'b1, 32'h40, 32'h1);
        drive(1, 1'b1, 1'b1, 32'h44, 32'h2);
        for (int k = 0; k < 8 && gq.size() == 0; k++) tick();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        drain();
        chk("tie_after_reset_seen", 32'(gq.size() > 0), 32'h1);
        if (gq.size() > 0) chk("tie_after_reset_m0", 32'(gq[0]), 32'h0);

        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int k = 0; k < 700; k++) begin
            for (int m = 0; m < 2; m++) begin
                if (pend[m] && exp_gnt[m][cyc]) begin
                    pend[m] = 1'b0;
                    drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
                end
                if (!pend[m] && $urandom_range(0, 2) == 0) new_random(m);
                else if (pend[m] && $urandom_range(0, 15) == 0) begin
                    pend[m] = 1'b0;
                    drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
                end
            end
            tick();
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        drain();
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
